// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings and defaults for the CPU run/step/halt sequencer.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_RUN       = 3'd2,
    ST_STEP_WAIT = 3'd3,
    ST_STEP_EXEC = 3'd4,
    ST_HALT      = 3'd5
  } state_e;

  // Why execution stopped; shared with the seven-segment display mux.
  typedef enum logic [1:0] {
    HR_NONE      = 2'd0,
    HR_SELF_LOOP = 2'd1,
    HR_TIMEOUT   = 2'd2,
    HR_ABORT     = 2'd3
  } halt_reason_e;

  localparam int unsigned DEF_RST_CYCLES = 4;
  localparam int unsigned DEF_MAX_CYCLES = 1000;
  localparam int unsigned DEF_CNT_W      = 16;

  // The CPU is out of reset in every state past RESET.
  function automatic logic cpu_live(input state_e s);
    return (s == ST_RUN) || (s == ST_STEP_WAIT) || (s == ST_STEP_EXEC) || (s == ST_HALT);
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_sync_edge.sv
// Two-flop synchroniser for a raw board input, plus a one-cycle rising-edge pulse.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign level_o = sync2_q;
  assign rise_o  = sync2_q & ~prev_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer: owns the CPU reset and clock-enable, counts enabled
// cycles and stops on a PC self-loop or an expired cycle budget.
//   state      | meaning
//   IDLE       | CPU held in reset, waiting for start
//   RESET      | CPU reset asserted for RST_CYCLES cycles
//   RUN        | free-running, cpu_en every cycle
//   STEP_WAIT  | CPU out of reset, waiting for a step press
//   STEP_EXEC  | one enabled cycle for a step press
//   HALT       | stopped, CPU state preserved for display
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES = DEF_RST_CYCLES,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned MAX_CYCLES = DEF_MAX_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             step_i,
  input  logic             step_mode_i,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      pc_next_i,
  output logic             cpu_rst_n_o,
  output logic             cpu_en_o,
  output logic             halted_o,
  output logic             timeout_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] cycle_cnt_o
);

  localparam logic [3:0]       RST_LOAD = 4'(RST_CYCLES - 1);
  localparam bit               TO_EN    = (MAX_CYCLES != 0);
  localparam logic [CNT_W-1:0] MAX_M1   = CNT_W'((MAX_CYCLES == 0) ? 0 : MAX_CYCLES - 1);

  logic start_lvl, step_rise;
  logic unused_start_rise, unused_step_lvl;

  sync_edge u_start_sync (
    .clk     (clk),
    .rst     (rst),
    .d_i     (start_i),
    .level_o (start_lvl),
    .rise_o  (unused_start_rise)
  );

  sync_edge u_step_sync (
    .clk     (clk),
    .rst     (rst),
    .d_i     (step_i),
    .level_o (unused_step_lvl),
    .rise_o  (step_rise)
  );

  state_e           state_q, state_d;
  logic [3:0]       rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             cpu_rst_n_q, cpu_rst_n_d;
  logic             halted_q, halted_d;
  logic             cpu_en;
  logic             halt_loop, halt_to;

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;

    // Enable drops in the same cycle start is seen low, before the abort lands.
    cpu_en    = start_lvl && ((state_q == ST_RUN) || (state_q == ST_STEP_EXEC));
    halt_loop = (pc_next_i == pc_i);
    halt_to   = TO_EN && (cnt_q == MAX_M1);

    if (!start_lvl && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_lvl) begin
            state_d   = ST_RESET;
            rst_cnt_d = RST_LOAD;
          end
        end
        ST_RESET: begin
          cnt_d     = '0;
          timeout_d = 1'b0;
          if (rst_cnt_q == 4'd0) state_d = step_mode_i ? ST_STEP_WAIT : ST_RUN;
          else                   rst_cnt_d = rst_cnt_q - 4'd1;
        end
        ST_RUN, ST_STEP_EXEC: begin
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          if (halt_to) timeout_d = 1'b1;
          if (halt_loop || halt_to)       state_d = ST_HALT;
          else if (state_q == ST_STEP_EXEC) state_d = ST_STEP_WAIT;
        end
        ST_STEP_WAIT: begin
          if (step_rise) state_d = ST_STEP_EXEC;
        end
        ST_HALT: ;
        default: state_d = ST_IDLE;
      endcase
    end

    // Registered from next state so the CPU reset never glitches.
    cpu_rst_n_d = cpu_live(state_d);
    halted_d    = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rst_cnt_q   <= 4'd0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      halted_q    <= halted_d;
    end
  end

  assign cpu_rst_n_o = cpu_rst_n_q;
  assign cpu_en_o    = cpu_en;
  assign halted_o    = halted_q;
  assign timeout_o   = timeout_q;
  assign state_o     = state_q;
  assign cycle_cnt_o = cnt_q;

endmodule
